// File: rtl/domain_rr_arb2_pkg.sv
// rtl/domain_rr_arb2_pkg.sv - shared types and helpers for domain_rr_arb2
package domain_rr_arb2_pkg;

    // Security-domain tag carried alongside every message.
    localparam int DOMAIN_W = 2;

    typedef enum logic [DOMAIN_W-1:0] {
        DOMAIN_L0 = 2'd0,   // normal world
        DOMAIN_L1 = 2'd1    // secure world
    } domain_e;

    // One-entry output buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Index of the winning requester among those pending; tie_idx breaks a tie.
    // Returns 0 when nothing is pending, callers qualify with the valids.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic tie_idx);
        if (v0 && v1) begin
            return tie_idx;
        end else if (v1) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/domain_rr_arb2_mux2.sv
// rtl/domain_rr_arb2_mux2.sv - two-input data mux feeding the arbiter output buffer
//
// Ports:
//   in0, in1 : candidate words (message and domain tag concatenated)
//   sel      : 0 picks in0, 1 picks in1
//   out      : selected word
module domain_rr_arb2_mux2 #(
    parameter int p_nbits = 1
) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic               sel,
    output logic [p_nbits-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/domain_rr_arb2.sv
// rtl/domain_rr_arb2.sv - two-input domain-tagged round-robin arbiter with one-entry output buffer
//
// Build option: ARB_TDM_EN selects strict time-slotted ownership (timing-channel
// isolation) instead of work-conserving round-robin.
//
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   in0_val/in0_rdy/in0_msg/in0_domain : requester 0 (normal world) val/rdy channel
//   in1_val/in1_rdy/in1_msg/in1_domain : requester 1 (secure world) val/rdy channel
//   out_val/out_rdy/out_msg/out_domain : buffered output val/rdy channel
//   sel                           : mux select, index of the input granted this cycle
module domain_rr_arb2
    import domain_rr_arb2_pkg::*;
#(
    parameter int p_nbits    = 32,
    parameter int p_slot_len = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                in0_val,
    output logic                in0_rdy,
    input  logic [p_nbits-1:0]  in0_msg,
    input  logic [DOMAIN_W-1:0] in0_domain,

    input  logic                in1_val,
    output logic                in1_rdy,
    input  logic [p_nbits-1:0]  in1_msg,
    input  logic [DOMAIN_W-1:0] in1_domain,

    output logic                out_val,
    input  logic                out_rdy,
    output logic [p_nbits-1:0]  out_msg,
    output logic [DOMAIN_W-1:0] out_domain,

    output logic                sel
);

    localparam int W = p_nbits + DOMAIN_W;

    if (p_slot_len < 1) begin : g_bad_slot_len
        $error("domain_rr_arb2: p_slot_len must be at least 1");
    end

    buf_state_e   state_q;
    buf_state_e   state_d;
    logic         can_accept;
    logic         gnt0;
    logic         gnt1;
    logic         sel_c;
    logic         enq;
    logic         deq;
    logic [W-1:0] mux_out;

    // A dequeue frees the slot in the same cycle, so a full buffer being
    // drained can still take a new message.
    assign can_accept = (state_q == BUF_EMPTY) || out_rdy;

`ifdef ARB_TDM_EN
    localparam int                CNT_W     = (p_slot_len > 1) ? $clog2(p_slot_len) : 1;
    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(p_slot_len - 1);

    logic [CNT_W-1:0] slot_cnt;
    logic             owner;

    // Slot counter free-runs regardless of traffic so grant timing leaks
    // nothing about the other domain's activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
            owner    <= 1'b0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            owner    <= ~owner;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    assign gnt0  = can_accept && !owner && in0_val;
    assign gnt1  = can_accept &&  owner && in1_val;
    assign sel_c = owner;
`else
    logic prio;
    logic pick;

    assign pick  = rr_pick(in0_val, in1_val, prio);
    assign gnt0  = can_accept && (in0_val || in1_val) && !pick;
    assign gnt1  = can_accept && (in0_val || in1_val) &&  pick;
    // With no grant the mux simply parks on the current priority holder.
    assign sel_c = (gnt0 || gnt1) ? pick : prio;

    // After serving input i, the other input takes priority on a tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (enq) begin
            prio <= gnt0;
        end
    end
`endif

    assign in0_rdy = gnt0 && !reset;
    assign in1_rdy = gnt1 && !reset;
    assign sel     = sel_c;

    // Grants already imply the matching valid, so any rdy is a transfer.
    assign enq = in0_rdy || in1_rdy;
    assign deq = (state_q == BUF_FULL) && out_rdy;

    domain_rr_arb2_mux2 #(
        .p_nbits (W)
    ) u_mux (
        .in0 ({in0_domain, in0_msg}),
        .in1 ({in1_domain, in1_msg}),
        .sel (sel_c),
        .out (mux_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enq) begin
            state_d = BUF_FULL;
        end else if (deq) begin
            state_d = BUF_EMPTY;
        end
    end

    // Payload and tag are captured together and only on enqueue, so they
    // hold steady through back-pressure and keep their value after a drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_msg    <= '0;
            out_domain <= '0;
        end else if (enq) begin
            {out_domain, out_msg} <= mux_out;
        end
    end

    assign out_val = (state_q == BUF_FULL);

endmodule

// File: tb/tb_domain_rr_arb2.sv
// tb/tb_domain_rr_arb2.sv - self-checking bench for domain_rr_arb2
module tb_domain_rr_arb2;
    import domain_rr_arb2_pkg::*;

    localparam int NB   = 32;
    localparam int SLOT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in0_val = 1'b0, in1_val = 1'b0, out_rdy = 1'b0;
    logic [NB-1:0] in0_msg = '0, in1_msg = '0;
    logic [1:0]    in0_domain = '0, in1_domain = '0;
    logic          in0_rdy, in1_rdy, out_val, sel;
    logic [NB-1:0] out_msg;
    logic [1:0]    out_domain;

    int checks = 0;
    int errors = 0;

    domain_rr_arb2 #(
        .p_nbits    (NB),
        .p_slot_len (SLOT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in0_val    (in0_val),
        .in0_rdy    (in0_rdy),
        .in0_msg    (in0_msg),
        .in0_domain (in0_domain),
        .in1_val    (in1_val),
        .in1_rdy    (in1_rdy),
        .in1_msg    (in1_msg),
        .in1_domain (in1_domain),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_msg    (out_msg),
        .out_domain (out_domain),
        .sel        (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buffer contents, who wins the next tie, and cycles elapsed since reset.
    logic          m_started = 1'b0;
    logic          m_full;
    logic [NB-1:0] m_msg;
    logic [1:0]    m_dom;
    int            m_turn;
    int            m_cycle;
    int            m_win;
    int            m_sel;
    logic          m_can;

    always @(negedge clk) begin
        if (reset) begin
            if (m_started) begin
                chk("rst_in0_rdy", in0_rdy, 0);
                chk("rst_in1_rdy", in1_rdy, 0);
                chk("rst_out_val", out_val, m_full);
            end
            m_full = 1'b0; m_msg = '0; m_dom = '0;
            m_turn = 0; m_cycle = 0; m_started = 1'b1;
        end else if (m_started) begin
            m_can = !m_full || out_rdy;
            m_win = -1;
`ifdef ARB_TDM_EN
            m_sel = (m_cycle / SLOT) % 2;
            if (m_can && ((m_sel == 0) ? in0_val : in1_val)) m_win = m_sel;
`else
            if (m_can) begin
                if (in0_val && in1_val) m_win = m_turn;
                else if (in0_val)       m_win = 0;
                else if (in1_val)       m_win = 1;
            end
            m_sel = (m_win >= 0) ? m_win : m_turn;
`endif
            chk("mdl_in0_rdy", in0_rdy, m_win == 0);
            chk("mdl_in1_rdy", in1_rdy, m_win == 1);
            chk("mdl_sel", sel, m_sel);
            chk("mdl_out_val", out_val, m_full);
            chk("mdl_out_msg", out_msg, m_msg);
            chk("mdl_out_domain", out_domain, m_dom);
            if (m_win >= 0) begin
                m_full = 1'b1;
                m_msg  = (m_win == 0) ? in0_msg : in1_msg;
                m_dom  = (m_win == 0) ? in0_domain : in1_domain;
                m_turn = 1 - m_win;
            end else if (m_full && out_rdy) begin
                m_full = 1'b0;
            end
            m_cycle++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v0, input logic [NB-1:0] m0, input logic [1:0] d0,
                          input logic v1, input logic [NB-1:0] m1, input logic [1:0] d1,
                          input logic ordy);
        in0_val = v0; in0_msg = m0; in0_domain = d0;
        in1_val = v1; in1_msg = m1; in1_domain = d1;
        out_rdy = ordy;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        set_in(0, '0, 0, 0, '0, 0, 0);
        tick;
        tick;
        reset = 1'b0;
    endtask

    typedef struct {
        logic v0;
        logic v1;
        logic ordy;
    } vec_t;

    vec_t tbl[12] = '{
        '{1, 0, 0}, '{1, 1, 0}, '{0, 1, 1}, '{1, 1, 1},
        '{0, 0, 0}, '{0, 0, 1}, '{1, 1, 1}, '{0, 1, 0},
        '{1, 0, 1}, '{1, 1, 0}, '{1, 1, 1}, '{0, 0, 1}
    };

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset;
`ifndef ARB_TDM_EN
        // First cycle after reset: single request is granted at once.
        set_in(1, 32'hA5, DOMAIN_L0, 0, '0, 0, 1);
        chk("first_in0_rdy", in0_rdy, 1);
        tick;
        set_in(0, '0, 0, 0, '0, 0, 1);
        chk("first_out_val", out_val, 1);
        chk("first_out_msg", out_msg, 32'hA5);
        chk("first_out_domain", out_domain, 0);
        tick;

        // Both held: grants alternate starting with 0.
        do_reset;
        for (int i = 0; i < 6; i++) begin
            set_in(1, 32'h100 + i, DOMAIN_L0, 1, 32'h200 + i, DOMAIN_L1, 1);
            chk("alt_in0_rdy", in0_rdy, (i % 2) == 0);
            chk("alt_sel", sel, i % 2);
            if (i > 0) chk("alt_out_domain", out_domain, (i - 1) % 2);
            tick;
        end

        // Back-pressure: buffer holds 0x205 from input 1.
        for (int k = 0; k < 3; k++) begin
            set_in(1, 32'h110 + k, DOMAIN_L0, 1, 32'h210 + k, DOMAIN_L1, 0);
            chk("stall_in0_rdy", in0_rdy, 0);
            chk("stall_in1_rdy", in1_rdy, 0);
            chk("stall_out_msg", out_msg, 32'h205);
            chk("stall_out_domain", out_domain, 1);
            tick;
        end
        set_in(1, 32'h120, DOMAIN_L0, 1, 32'h220, DOMAIN_L1, 1);
        chk("resume_in0_rdy", in0_rdy, 1);
        chk("resume_out_val", out_val, 1);
        tick;
        set_in(0, '0, 0, 0, '0, 0, 0);
        chk("resume_out_msg", out_msg, 32'h120);
        chk("resume_out_val2", out_val, 1);

        // Reset while full drops the message and clears priority.
        reset = 1'b1;
        set_in(1, 32'h130, DOMAIN_L0, 1, 32'h230, DOMAIN_L1, 1);
        chk("rstfull_in0_rdy", in0_rdy, 0);
        tick;
        reset = 1'b0;
        #1;
        chk("rstfull_out_val", out_val, 0);
        chk("rstfull_prio_in0", in0_rdy, 1);
        tick;

        // Mixed directed vectors, checked by the model only.
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].v0, 32'h400 + i, DOMAIN_L0, tbl[i].v1, 32'h500 + i, DOMAIN_L1, tbl[i].ordy);
            tick;
        end
`else
        // Only requester 1 active: it is served only in its own slot.
        for (int i = 0; i < 12; i++) begin
            set_in(0, '0, 0, 1, 32'h300 + i, DOMAIN_L1, 1);
            chk("tdm_in1_rdy", in1_rdy, (i >= 4) && (i < 8));
            chk("tdm_in0_rdy", in0_rdy, 0);
            tick;
        end
        // Both active: four consecutive grants to each owner in turn.
        do_reset;
        for (int i = 0; i < 16; i++) begin
            set_in(1, 32'h600 + i, DOMAIN_L0, 1, 32'h700 + i, DOMAIN_L1, 1);
            chk("tdm_sel", sel, (i / 4) % 2);
            chk("tdm_gnt0", in0_rdy, ((i / 4) % 2) == 0);
            chk("tdm_gnt1", in1_rdy, ((i / 4) % 2) == 1);
            tick;
        end
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].v0, 32'h400 + i, DOMAIN_L0, tbl[i].v1, 32'h500 + i, DOMAIN_L1, tbl[i].ordy);
            tick;
        end
`endif
        set_in(0, '0, 0, 0, '0, 0, 1);
        tick;
        tick;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
